// File: rtl/breath_key_ctrl_pkg.sv
// Shared constants and types for the breathing-LED key configuration stage.
// MAX_NUM is shared with the downstream PWM stage.
package breath_pkg;

    localparam int unsigned MAX_NUM = 50_000;

    localparam logic [19:0] DEBOUNCE_CNT_DEF = 20'd1_000_000;

    localparam logic [1:0] STEP_RESET_IDX_DEF = 2'd2;

    // Index 0 is the lowest packed slot; every entry divides MAX_NUM.
    localparam logic [3:0][15:0] STEP_TABLE = {
        16'd50, 16'd25, 16'd10, 16'd5
    };

    typedef enum logic [1:0] {
        IDLE_HIGH,
        WAIT_LOW,
        HELD_LOW,
        WAIT_HIGH
    } db_state_t;

endpackage

// File: rtl/breath_key_ctrl_if.sv
// Configuration bundle from the key stage to the PWM stage.
// The key stage drives it through master, the PWM stage reads through slave.
interface breath_key_ctrl_if;

    logic [15:0] duty_step;
    logic [1:0]  speed_idx;
    logic        breath_en;
    logic        cfg_update;

    modport master (
        output duty_step,
        output speed_idx,
        output breath_en,
        output cfg_update
    );

    modport slave (
        input duty_step,
        input speed_idx,
        input breath_en,
        input cfg_update
    );

endinterface

// File: rtl/breath_key_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce FSM and press pulse.
// Only accepted press edges produce a pulse; releases are silent.
module key_debounce
    import breath_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic        r_sync_q1;
    logic        r_sync_q2;
    db_state_t   r_state;
    logic [19:0] r_cnt;
    logic        r_press;

    db_state_t   w_state_nxt;
    logic [19:0] w_cnt_nxt;
    logic        w_press_nxt;
    logic        w_cnt_done;

    // Released level is 1 so a key held through reset still yields a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync_q1 <= 1'b1;
            r_sync_q2 <= 1'b1;
        end else begin
            r_sync_q1 <= i_key_n;
            r_sync_q2 <= r_sync_q1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    assign w_cnt_done = (r_cnt == DEBOUNCE_CNT - 20'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        unique case (r_state)
            IDLE_HIGH: begin
                if (!r_sync_q2) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (r_sync_q2) begin
                    w_state_nxt = IDLE_HIGH;
                end else if (w_cnt_done) begin
                    w_state_nxt = HELD_LOW;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            HELD_LOW: begin
                if (r_sync_q2) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!r_sync_q2) begin
                    w_state_nxt = HELD_LOW;
                end else if (w_cnt_done) begin
                    w_state_nxt = IDLE_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
        endcase
    end

    assign o_press = r_press;

endmodule

// File: rtl/breath_key_ctrl.sv
// Key-driven configuration for the breathing-LED PWM stage: speed key
// cycles the ramp step, pause key toggles breathing.
module breath_key_ctrl
    import breath_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CNT   = DEBOUNCE_CNT_DEF,
    parameter logic [1:0]  STEP_RESET_IDX = STEP_RESET_IDX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key_speed,
    input  logic              key_pause,
    breath_key_ctrl_if.master cfg_if
);

    logic        w_speed_press;
    logic        w_pause_press;
    logic [1:0]  w_idx_nxt;

    logic [1:0]  r_speed_idx;
    logic [15:0] r_duty_step;
    logic        r_breath_en;
    logic        r_cfg_update;

    key_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_db_speed (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_key_n   (key_speed),
        .o_press   (w_speed_press)
    );

    key_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_db_pause (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_key_n   (key_pause),
        .o_press   (w_pause_press)
    );

    // 2-bit add wraps 3 -> 0 on its own.
    assign w_idx_nxt = r_speed_idx + 2'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_speed_idx  <= STEP_RESET_IDX;
            r_duty_step  <= STEP_TABLE[STEP_RESET_IDX];
            r_breath_en  <= 1'b1;
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= w_speed_press | w_pause_press;
            if (w_speed_press) begin
                r_speed_idx <= w_idx_nxt;
                r_duty_step <= STEP_TABLE[w_idx_nxt];
            end
            if (w_pause_press) begin
                r_breath_en <= ~r_breath_en;
            end
        end
    end

    assign cfg_if.duty_step  = r_duty_step;
    assign cfg_if.speed_idx  = r_speed_idx;
    assign cfg_if.breath_en  = r_breath_en;
    assign cfg_if.cfg_update = r_cfg_update;

endmodule

// File: tb/tb_breath_key_ctrl.sv
// Directed bench for breath_key_ctrl with DEBOUNCE_CNT = 4.
// Keys change on falling edges; outputs are sampled on falling edges.
module tb_breath_key_ctrl;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_speed = 1'b1;
    logic key_pause = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    int g_pulses;
    int g_first;
    int g_cyc;

    breath_key_ctrl_if u_if ();

    breath_key_ctrl #(
        .DEBOUNCE_CNT   (20'd4),
        .STEP_RESET_IDX (2'd2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_speed (key_speed),
        .key_pause (key_pause),
        .cfg_if    (u_if)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        g_pulses = 0;
        g_first  = -1;
        g_cyc    = 0;
    endtask

    // g_cyc is the index of the rising edge just passed, counted from the
    // first edge after the last clr().
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (u_if.cfg_update === 1'b1) begin
                if (g_pulses == 0) g_first = g_cyc;
                g_pulses++;
            end
            g_cyc++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] idx,
                           input logic [15:0] duty, input logic en);
        chk({tag, "_idx"}, 32'(u_if.speed_idx), 32'(idx));
        chk({tag, "_duty"}, 32'(u_if.duty_step), 32'(duty));
        chk({tag, "_en"}, 32'(u_if.breath_en), 32'(en));
    endtask

    initial begin
        // Reset values, then idle with no keys
        cyc();
        cyc();
        chk_out("rst_hold", 2'd2, 16'd25, 1'b1);
        chk("rst_hold_upd", 32'(u_if.cfg_update), 32'd0);
        sys_rst_n = 1'b1;
        clr();
        run(8);
        chk("idle_pulses", g_pulses, 0);
        chk_out("idle", 2'd2, 16'd25, 1'b1);

        // Speed press: 2 -> 3, update at edge 7
        key_speed = 1'b0;
        clr();
        run(10);
        key_speed = 1'b1;
        chk("spd1_pulses", g_pulses, 1);
        chk("spd1_edge", g_first, 7);
        chk_out("spd1", 2'd3, 16'd50, 1'b1);
        clr();
        run(14);
        chk("spd1_rel_pulses", g_pulses, 0);

        // Second speed press wraps 3 -> 0
        key_speed = 1'b0;
        clr();
        run(10);
        key_speed = 1'b1;
        chk("spd2_pulses", g_pulses, 1);
        chk("spd2_edge", g_first, 7);
        chk_out("spd2", 2'd0, 16'd5, 1'b1);
        clr();
        run(14);
        chk("spd2_rel_pulses", g_pulses, 0);

        // Short pause glitch is rejected
        key_pause = 1'b0;
        clr();
        run(3);
        key_pause = 1'b1;
        run(12);
        chk("glitch_pulses", g_pulses, 0);
        chk("glitch_en", 32'(u_if.breath_en), 32'd1);

        // Bouncy pause press gives one toggle
        key_pause = 1'b0;
        clr();
        run(2);
        key_pause = 1'b1;
        run(1);
        key_pause = 1'b0;
        run(8);
        key_pause = 1'b1;
        run(1);
        key_pause = 1'b0;
        run(2);
        key_pause = 1'b1;
        run(16);
        chk("bounce_pulses", g_pulses, 1);
        chk("bounce_edge", g_first, 10);
        chk_out("bounce", 2'd0, 16'd5, 1'b0);

        // Reset restores defaults from a non-default configuration
        sys_rst_n = 1'b0;
        #1;
        chk_out("rst2", 2'd2, 16'd25, 1'b1);
        cyc();
        sys_rst_n = 1'b1;
        clr();
        run(4);
        chk("rst2_pulses", g_pulses, 0);

        // Both keys together: one update carrying both changes
        key_speed = 1'b0;
        key_pause = 1'b0;
        clr();
        run(10);
        key_speed = 1'b1;
        key_pause = 1'b1;
        chk("both_pulses", g_pulses, 1);
        chk("both_edge", g_first, 7);
        chk_out("both", 2'd3, 16'd50, 1'b0);
        clr();
        run(14);
        chk("both_rel_pulses", g_pulses, 0);

        // Reset mid-press with key held through release
        key_speed = 1'b0;
        clr();
        run(3);
        sys_rst_n = 1'b0;
        #1;
        chk_out("midrst", 2'd2, 16'd25, 1'b1);
        chk("midrst_upd", 32'(u_if.cfg_update), 32'd0);
        clr();
        run(2);
        chk("midrst_hold_pulses", g_pulses, 0);
        sys_rst_n = 1'b1;
        clr();
        run(14);
        key_speed = 1'b1;
        chk("midrst_pulses", g_pulses, 1);
        chk("midrst_edge", g_first, 7);
        chk_out("midrst_after", 2'd3, 16'd50, 1'b1);
        clr();
        run(14);
        chk("midrst_rel_pulses", g_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
